// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: RAM word and state, arbiter state and grant id.
// The arbiter and the caches on the non-snooping path import these types.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Grant owner: which class (data/instruction) and which core.
  typedef struct packed {
    logic is_data;
    logic core;
  } gnt_id_t;

  // Saturating 4-bit increment, used by the instruction age counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the requester named by ptr wins if it is asking,
// otherwise the other one does.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner,
  output logic       any
);

  assign any    = |req;
  assign winner = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/mem_arbiter.sv
// Four-way arbiter (icache0/1, dcache0/1) in front of the single RAM port.
// One transaction at a time; data beats instructions unless fetch has aged out.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS      = 2,
  parameter int AGE_LIMIT = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  // instruction ports
  input  logic      [CPUS-1:0] iREN,
  input  word_t     [CPUS-1:0] iaddr,
  output logic      [CPUS-1:0] iwait,
  output word_t     [CPUS-1:0] iload,
  // data ports
  input  logic      [CPUS-1:0] dREN,
  input  logic      [CPUS-1:0] dWEN,
  input  word_t     [CPUS-1:0] daddr,
  input  word_t     [CPUS-1:0] dstore,
  output logic      [CPUS-1:0] dwait,
  output word_t     [CPUS-1:0] dload,
  // RAM port
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  // status
  output logic                 gnt_valid,
  output gnt_id_t              gnt_id,
  output logic                 ram_err
);

  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

  arb_state_t state_q, state_d;
  gnt_id_t    gnt_id_q, gnt_id_d;
  logic       dptr_q, dptr_d;
  logic       iptr_q, iptr_d;
  logic [3:0] istarve_q, istarve_d;
  logic       ram_err_q;

  logic [1:0] d_req;
  logic       d_win, d_any;
  logic       i_win, i_any;
  logic       owner_req;
  logic       starve_hit;

  assign d_req      = dREN | dWEN;
  assign starve_hit = (istarve_q == AGE_MAX);

  rr_pick2 u_dpick (
    .req    (d_req),
    .ptr    (dptr_q),
    .winner (d_win),
    .any    (d_any)
  );

  rr_pick2 u_ipick (
    .req    (iREN),
    .ptr    (iptr_q),
    .winner (i_win),
    .any    (i_any)
  );

  // The owner's request still being up is what keeps the grant alive.
  assign owner_req = gnt_id_q.is_data ? d_req[gnt_id_q.core] : iREN[gnt_id_q.core];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    dptr_d    = dptr_q;
    iptr_d    = iptr_q;
    istarve_d = istarve_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = '1;
    dwait     = '1;
    iload     = '0;
    dload     = '0;

    unique case (state_q)
      IDLE: begin
        if (d_any || i_any) begin
          state_d = OWN;
          if (i_any && (starve_hit || !d_any)) begin
            gnt_id_d  = '{is_data: 1'b0, core: i_win};
            iptr_d    = ~i_win;
            istarve_d = '0;
          end else begin
            gnt_id_d = '{is_data: 1'b1, core: d_win};
            dptr_d   = ~d_win;
            if (i_any) istarve_d = sat_inc4(istarve_q, AGE_MAX);
          end
        end
      end

      OWN: begin
        if (gnt_id_q.is_data) dload[gnt_id_q.core] = ramload;
        else                  iload[gnt_id_q.core] = ramload;

        if (!owner_req) begin
          // Withdrawn: RAM sees nothing this cycle and no completion is signalled.
          state_d = IDLE;
        end else begin
          if (gnt_id_q.is_data) begin
            ramaddr  = daddr[gnt_id_q.core];
            ramstore = dstore[gnt_id_q.core];
            ramWEN   = dWEN[gnt_id_q.core];
            ramREN   = dREN[gnt_id_q.core] & ~dWEN[gnt_id_q.core];
          end else begin
            ramaddr = iaddr[gnt_id_q.core];
            ramREN  = 1'b1;
          end

          if (ramstate == ACCESS) begin
            state_d = IDLE;
            if (gnt_id_q.is_data) dwait[gnt_id_q.core] = 1'b0;
            else                  iwait[gnt_id_q.core] = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      dptr_q    <= 1'b0;
      iptr_q    <= 1'b0;
      istarve_q <= '0;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      dptr_q    <= dptr_d;
      iptr_q    <= iptr_d;
      istarve_q <= istarve_d;
      if (state_q == OWN && ramstate == ERROR) ram_err_q <= 1'b1;
    end
  end

  assign gnt_valid = (state_q == OWN);
  assign gnt_id    = gnt_id_q;
  assign ram_err   = ram_err_q;

endmodule
